// File: rtl/lrn_square_sum_pkg.sv
// rtl/lrn_square_sum_pkg.sv - shared types and helpers for the LRN square-sum producer
package lrn_square_sum_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Room for a full OP_WIDTH square (minus dropped fraction) times the window depth.
  function automatic int acc_width(input int op_width, input int frac_bits, input int lrn_window);
    return 2 * op_width - frac_bits + clog2(lrn_window);
  endfunction

  function automatic logic [63:0] saturate(input logic [63:0] a, input int op_width);
    logic [63:0] lim;
    lim = (64'd1 << (op_width - 1)) - 64'd1;
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/lrn_square_sum_lane.sv
// rtl/lrn_square_sum_lane.sv - one lane: square window, raw-input history and running sum
module lrn_sq_lane
  import lrn_square_sum_pkg::*;
#(
  parameter int OP_WIDTH   = 16,
  parameter int FRAC_BITS  = 8,
  parameter int LRN_WINDOW = 5,
  parameter int ACC_WIDTH  = acc_width(16, 8, 5)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       shift,
  input  logic                       clear,
  input  logic signed [OP_WIDTH-1:0] din,
  output logic [ACC_WIDTH-1:0]       acc_next,
  output logic [OP_WIDTH-1:0]        center_next
);

  localparam int H    = (LRN_WINDOW - 1) / 2;
  localparam int SQ_W = 2 * OP_WIDTH - FRAC_BITS;

  logic signed [2*OP_WIDTH-1:0] prod;
  logic [SQ_W-1:0]              sq;
  logic [SQ_W-1:0]              w [LRN_WINDOW];
  // Raw history only up to the centre tap; older inputs never reach an output.
  logic [OP_WIDTH-1:0]          x [H];
  logic [ACC_WIDTH-1:0]         acc;

  assign prod        = din * din;
  assign sq          = SQ_W'(prod >>> FRAC_BITS);
  assign acc_next    = acc + ACC_WIDTH'(sq) - ACC_WIDTH'(w[LRN_WINDOW-1]);
  assign center_next = x[H-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      for (int i = 0; i < LRN_WINDOW; i++) w[i] <= '0;
      for (int i = 0; i < H; i++) x[i] <= '0;
    end else if (clear) begin
      acc <= '0;
      for (int i = 0; i < LRN_WINDOW; i++) w[i] <= '0;
      for (int i = 0; i < H; i++) x[i] <= '0;
    end else if (shift) begin
      acc  <= acc_next;
      w[0] <= sq;
      for (int i = 1; i < LRN_WINDOW; i++) w[i] <= w[i-1];
      x[0] <= din;
      for (int i = 1; i < H; i++) x[i] <= x[i-1];
    end
  end

endmodule

// File: rtl/lrn_square_sum.sv
// rtl/lrn_square_sum.sv - cross-channel sliding sum of squares feeding the LRN normaliser
module lrn_square_sum
  import lrn_square_sum_pkg::*;
#(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_PE     = 4,
  parameter int FRAC_BITS  = 8,
  parameter int LRN_WINDOW = 5,
  parameter int DATA_WIDTH = OP_WIDTH * NUM_PE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  data_last,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] square_sum,
  output logic [DATA_WIDTH-1:0] lrn_center,
  output logic                  out_valid
);

  localparam int H     = (LRN_WINDOW - 1) / 2;
  localparam int ACC_W = acc_width(OP_WIDTH, FRAC_BITS, LRN_WINDOW);
  localparam int CNT_W = clog2(H) + 1;

  state_t              state;
  logic [H-1:0]        v;
  logic [CNT_W-1:0]    flush_cnt;
  logic                slot_free;
  logic                in_fire;
  logic                flush_shift;
  logic                flush_done;
  logic                shift;
  logic                load;
  logic [DATA_WIDTH-1:0] sum_next;
  logic [DATA_WIDTH-1:0] center_vec;

  assign slot_free   = !out_valid || out_ready;
  assign in_ready    = reset && slot_free && (state != FLUSH);
  assign in_fire     = data_valid && in_ready;
  assign flush_shift = (state == FLUSH) && slot_free;
  assign flush_done  = flush_shift && (flush_cnt == CNT_W'(H - 1));
  assign shift       = in_fire || flush_shift;
  // Post-shift V[H] is the bit currently sitting at V[H-1].
  assign load        = shift && v[H-1];

  for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
    logic [ACC_W-1:0]    acc_next;
    logic [OP_WIDTH-1:0] center_next;

    lrn_sq_lane #(
      .OP_WIDTH  (OP_WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .LRN_WINDOW(LRN_WINDOW),
      .ACC_WIDTH (ACC_W)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .shift      (shift),
      .clear      (flush_done),
      .din        (in_fire ? data_in[g*OP_WIDTH +: OP_WIDTH] : '0),
      .acc_next   (acc_next),
      .center_next(center_next)
    );

    assign sum_next[g*OP_WIDTH +: OP_WIDTH]   = OP_WIDTH'(saturate(64'(acc_next), OP_WIDTH));
    assign center_vec[g*OP_WIDTH +: OP_WIDTH] = center_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      v         <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE:   if (in_fire) state <= data_last ? FLUSH : STREAM;
        STREAM: if (in_fire && data_last) state <= FLUSH;
        FLUSH: begin
          if (flush_done) begin
            flush_cnt <= '0;
            state     <= IDLE;
          end else if (flush_shift) begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (flush_done) v <= '0;
      else if (shift) v <= H'({v, in_fire});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      square_sum <= '0;
      lrn_center <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      square_sum <= sum_next;
      lrn_center <= center_vec;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
